// File: rtl/nmr_seq_pkg.sv
// Shared definitions for the CPMG gate-train sequencer: FSM states and phase-select codes.
package nmr_seq_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    IDLY = 3'd1,
    P1   = 3'd2,
    D1   = 3'd3,
    PN   = 3'd4,
    DN   = 3'd5,
    FIN  = 3'd6
  } state_t;

  localparam logic [1:0] PH_0   = 2'd0;
  localparam logic [1:0] PH_90  = 2'd1;
  localparam logic [1:0] PH_180 = 2'd2;
  localparam logic [1:0] PH_270 = 2'd3;

endpackage

// File: rtl/nmr_dur_counter.sv
// Phase duration down-counter shared by every phase of the train.
module nmr_dur_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] value,
  input  logic                 enable,
  output logic                 tc
);

  logic [CNT_WIDTH-1:0] cnt;

  // A zero length behaves like one cycle, so the load value saturates at 0.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      cnt <= '0;
    else if (load)
      cnt <= (value == '0) ? '0 : value - 1'b1;
    else if (enable && cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/nmr_cpmg_streamer.sv
// CPMG sequencer: IDLY, P1, D1 then n_echo PN/DN pairs, one START/DONE handshake per train.
module nmr_cpmg_streamer
  import nmr_seq_pkg::*;
#(
  parameter int CNT_WIDTH  = 32,
  parameter int ECHO_WIDTH = 16,
  parameter int PH_WIDTH   = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic                  ABORT,
  input  logic [CNT_WIDTH-1:0]  idly,
  input  logic [CNT_WIDTH-1:0]  p1_len,
  input  logic [CNT_WIDTH-1:0]  d1_len,
  input  logic [CNT_WIDTH-1:0]  pn_len,
  input  logic [CNT_WIDTH-1:0]  dn_len,
  input  logic [ECHO_WIDTH-1:0] n_echo,
  input  logic [PH_WIDTH-1:0]   p1_ph,
  input  logic [PH_WIDTH-1:0]   pn_ph,
  output logic                  OUT,
  output logic [PH_WIDTH-1:0]   PH,
  output logic                  ACQ,
  output logic [ECHO_WIDTH-1:0] ECHO_IDX,
  output logic                  BUSY,
  output logic                  DONE
);

  state_t                state;
  logic [CNT_WIDTH-1:0]  p1_s, d1_s, pn_s, dn_s;
  logic [ECHO_WIDTH-1:0] n_s;
  logic [PH_WIDTH-1:0]   p1_ph_s, pn_ph_s;

  logic                  cnt_load;
  logic [CNT_WIDTH-1:0]  cnt_val;
  logic                  tc;

  // The launch edge loads IDLY straight from the port, since the shadow regs fill on that same edge.
  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = '0;
    if (!ABORT) begin
      case (state)
        IDLE: if (START)                    begin cnt_load = 1'b1; cnt_val = idly; end
        IDLY: if (tc)                       begin cnt_load = 1'b1; cnt_val = p1_s; end
        P1:   if (tc)                       begin cnt_load = 1'b1; cnt_val = d1_s; end
        D1:   if (tc && n_s != '0)          begin cnt_load = 1'b1; cnt_val = pn_s; end
        PN:   if (tc)                       begin cnt_load = 1'b1; cnt_val = dn_s; end
        DN:   if (tc && ECHO_IDX != n_s)    begin cnt_load = 1'b1; cnt_val = pn_s; end
        default: ;
      endcase
    end
  end

  nmr_dur_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
    .CLK    (CLK),
    .RST    (RST),
    .load   (cnt_load),
    .value  (cnt_val),
    .enable (1'b1),
    .tc     (tc)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      OUT      <= 1'b0;
      PH       <= '0;
      ACQ      <= 1'b0;
      ECHO_IDX <= '0;
      BUSY     <= 1'b0;
      DONE     <= 1'b1;
      p1_s     <= '0;
      d1_s     <= '0;
      pn_s     <= '0;
      dn_s     <= '0;
      n_s      <= '0;
      p1_ph_s  <= '0;
      pn_ph_s  <= '0;
    end else if (ABORT) begin
      state    <= IDLE;
      OUT      <= 1'b0;
      PH       <= '0;
      ACQ      <= 1'b0;
      ECHO_IDX <= '0;
      BUSY     <= 1'b0;
      DONE     <= 1'b1;
    end else begin
      case (state)
        IDLE: if (START) begin
          p1_s    <= p1_len;
          d1_s    <= d1_len;
          pn_s    <= pn_len;
          dn_s    <= dn_len;
          n_s     <= n_echo;
          p1_ph_s <= p1_ph;
          pn_ph_s <= pn_ph;
          state   <= IDLY;
          BUSY    <= 1'b1;
          DONE    <= 1'b0;
        end
        IDLY: if (tc) begin
          state <= P1;
          OUT   <= 1'b1;
          PH    <= p1_ph_s;
        end
        P1: if (tc) begin
          state <= D1;
          OUT   <= 1'b0;
          PH    <= '0;
        end
        D1: if (tc) begin
          if (n_s == '0) begin
            state <= FIN;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
          end else begin
            state    <= PN;
            ECHO_IDX <= {{(ECHO_WIDTH-1){1'b0}}, 1'b1};
            OUT      <= 1'b1;
            PH       <= pn_ph_s;
          end
        end
        PN: if (tc) begin
          state <= DN;
          OUT   <= 1'b0;
          PH    <= '0;
          ACQ   <= 1'b1;
        end
        DN: if (tc) begin
          ACQ <= 1'b0;
          if (ECHO_IDX == n_s) begin
            state    <= FIN;
            ECHO_IDX <= '0;
            BUSY     <= 1'b0;
            DONE     <= 1'b1;
          end else begin
            state    <= PN;
            ECHO_IDX <= ECHO_IDX + 1'b1;
            OUT      <= 1'b1;
            PH       <= pn_ph_s;
          end
        end
        FIN: if (!START) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nmr_cpmg_streamer.sv
// Bench for nmr_cpmg_streamer: per-cycle waveform checks against a phase-list model of the train.
module tb_nmr_cpmg_streamer;

  typedef struct {
    int unsigned idly, p1, d1, pn, dn, n;
    logic [1:0]  p1ph, pnph;
  } cfg_t;

  logic        CLK, RST, START, ABORT;
  logic [31:0] idly, p1_len, d1_len, pn_len, dn_len;
  logic [15:0] n_echo;
  logic [1:0]  p1_ph, pn_ph;
  logic        OUT, ACQ, BUSY, DONE;
  logic [1:0]  PH;
  logic [15:0] ECHO_IDX;

  int errors = 0;
  int checks = 0;
  logic [21:0] exp_q[$];
  localparam logic [21:0] IDLE_VEC = 22'h1;

  nmr_cpmg_streamer #(.CNT_WIDTH(32), .ECHO_WIDTH(16), .PH_WIDTH(2)) dut (
    .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT),
    .idly(idly), .p1_len(p1_len), .d1_len(d1_len), .pn_len(pn_len), .dn_len(dn_len),
    .n_echo(n_echo), .p1_ph(p1_ph), .pn_ph(pn_ph),
    .OUT(OUT), .PH(PH), .ACQ(ACQ), .ECHO_IDX(ECHO_IDX), .BUSY(BUSY), .DONE(DONE)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic int unsigned mx(input int unsigned x);
    return (x == 0) ? 1 : x;
  endfunction

  function automatic logic [21:0] vec(input logic o, input logic [1:0] ph, input logic acq,
                                      input logic [15:0] idx, input logic busy, input logic done);
    return {o, ph, acq, idx, busy, done};
  endfunction

  function automatic logic [21:0] obs();
    return {OUT, PH, ACQ, ECHO_IDX, BUSY, DONE};
  endfunction

  // Expected waveform, one entry per cycle from the first IDLY cycle through the FIN cycle.
  function automatic void build(input cfg_t c);
    exp_q.delete();
    repeat (mx(c.idly)) exp_q.push_back(vec(1'b0, 2'd0, 1'b0, 16'd0, 1'b1, 1'b0));
    repeat (mx(c.p1))   exp_q.push_back(vec(1'b1, c.p1ph, 1'b0, 16'd0, 1'b1, 1'b0));
    repeat (mx(c.d1))   exp_q.push_back(vec(1'b0, 2'd0, 1'b0, 16'd0, 1'b1, 1'b0));
    for (int unsigned e = 1; e <= c.n; e++) begin
      repeat (mx(c.pn)) exp_q.push_back(vec(1'b1, c.pnph, 1'b0, 16'(e), 1'b1, 1'b0));
      repeat (mx(c.dn)) exp_q.push_back(vec(1'b0, 2'd0, 1'b1, 16'(e), 1'b1, 1'b0));
    end
    exp_q.push_back(IDLE_VEC);
  endfunction

  function automatic cfg_t rand_cfg(input int unsigned max_n);
    cfg_t c;
    c.idly = $urandom_range(0, 6);
    c.p1   = $urandom_range(0, 6);
    c.d1   = $urandom_range(0, 6);
    c.pn   = $urandom_range(0, 6);
    c.dn   = $urandom_range(0, 6);
    c.n    = $urandom_range(0, max_n);
    c.p1ph = 2'($urandom_range(0, 3));
    c.pnph = 2'($urandom_range(0, 3));
    return c;
  endfunction

  function automatic cfg_t mk(input int unsigned a, b, d, e, f, n, input logic [1:0] x, y);
    cfg_t c;
    c.idly = a; c.p1 = b; c.d1 = d; c.pn = e; c.dn = f; c.n = n; c.p1ph = x; c.pnph = y;
    return c;
  endfunction

  task automatic apply(input cfg_t c);
    idly = c.idly; p1_len = c.p1; d1_len = c.d1; pn_len = c.pn; dn_len = c.dn;
    n_echo = 16'(c.n); p1_ph = c.p1ph; pn_ph = c.pnph;
  endtask

  task automatic check(input string tag, input logic [21:0] o, input logic [21:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic check_int(input string tag, input int o, input int e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  // Launch one train and compare every cycle; optionally hold START, scramble inputs, or abort.
  task automatic run_train(input cfg_t c, input bit hold, input bit scramble, input int abort_at);
    int busy_seen = 0;
    build(c);
    @(negedge CLK);
    apply(c);
    START = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(posedge CLK); #1;
      if (i == 0 && !hold) START = 1'b0;
      if (scramble && i == 1) apply(rand_cfg(5));
      check("train", obs(), exp_q[i]);
      if (BUSY) busy_seen++;
      if (abort_at == i) begin
        ABORT = 1'b1;
        @(posedge CLK); #1;
        ABORT = 1'b0;
        check("abort", obs(), IDLE_VEC);
        return;
      end
    end
    check_int("busy_cycles", busy_seen,
              int'(mx(c.idly) + mx(c.p1) + mx(c.d1) + c.n * (mx(c.pn) + mx(c.dn))));
    if (hold) begin
      repeat (4) begin
        @(posedge CLK); #1;
        check("hold_no_relaunch", obs(), IDLE_VEC);
      end
      START = 1'b0;
    end
    @(posedge CLK); #1;
    check("back_to_idle", obs(), IDLE_VEC);
  endtask

  initial begin
    cfg_t c;
    RST = 1'b1; START = 1'b0; ABORT = 1'b0;
    apply(mk(0, 0, 0, 0, 0, 0, 2'd0, 2'd0));
    #12;
    check("reset", obs(), IDLE_VEC);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK); #1;
    check("idle_after_reset", obs(), IDLE_VEC);

    run_train(mk(3, 2, 4, 7, 7, 0, 2'd1, 2'd2), 1'b0, 1'b0, -1);
    run_train(mk(2, 2, 3, 4, 5, 3, 2'd1, 2'd2), 1'b0, 1'b0, -1);
    run_train(mk(0, 0, 0, 0, 0, 1, 2'd3, 2'd1), 1'b0, 1'b0, -1);

    c = rand_cfg(4);
    c.n = 3;
    run_train(c, 1'b0, 1'b0, int'(mx(c.idly) + mx(c.p1) + mx(c.d1) + mx(c.pn) + mx(c.dn)));
    run_train(c, 1'b0, 1'b0, -1);

    run_train(rand_cfg(3), 1'b1, 1'b0, -1);
    run_train(rand_cfg(3), 1'b0, 1'b0, -1);
    run_train(rand_cfg(4), 1'b0, 1'b1, -1);

    // Reset in the middle of P1 must clear outputs without waiting for an edge.
    c = mk(2, 5, 2, 2, 2, 2, 2'd3, 2'd1);
    @(negedge CLK);
    apply(c);
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("mid_p1", obs(), vec(1'b1, 2'd3, 1'b0, 16'd0, 1'b1, 1'b0));
    #2 RST = 1'b1;
    #1 check("async_reset", obs(), IDLE_VEC);
    @(negedge CLK);
    RST = 1'b0;
    run_train(c, 1'b0, 1'b0, -1);

    for (int t = 0; t < 8; t++)
      run_train(rand_cfg(4), (t % 2) == 1, (t % 3) == 0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
